// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Shares the single-port dmem between the core MEM stage and a debug port.
// Define DMEM_ARB_STARVE_EN to enable forced debug grants after STARVE_MAX.
// Rev     : 1.0
// ============================================================================
module dmem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] D_IDLE = 2'd0;
   localparam logic [1:0] D_WAIT = 2'd1;
   localparam logic [1:0] D_ACK  = 2'd2;

   localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_ack;
   logic [31:0] r_rdata;
   logic        w_grant;
   logic        w_starved;

`ifdef DMEM_ARB_STARVE_EN
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;

   assign w_starved = (r_cnt == c_starve_max);

   // Counts consecutive denied cycles of the current debug request only.
   always_comb begin
      w_cnt_nxt = 4'd0;
      if (dbg_req && core_req) begin
         if (r_state == D_IDLE)
            w_cnt_nxt = 4'd1;
         else if (r_state == D_WAIT && !w_starved)
            w_cnt_nxt = r_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= 4'd0;
      else
         r_cnt <= w_cnt_nxt;
   end

   assign core_stall = w_grant & core_req;
`else
   logic [3:0] w_unused_starve;

   assign w_unused_starve = c_starve_max;
   assign w_starved       = 1'b0;
   assign core_stall      = 1'b0;
`endif

   always_comb begin
      w_grant     = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         D_IDLE: begin
            if (dbg_req) begin
               if (!core_req) begin
                  w_grant     = 1'b1;
                  w_state_nxt = D_ACK;
               end else begin
                  w_state_nxt = D_WAIT;
               end
            end
         end
         D_WAIT: begin
            if (!dbg_req) begin
               w_state_nxt = D_IDLE;
            end else if (!core_req || w_starved) begin
               w_grant     = 1'b1;
               w_state_nxt = D_ACK;
            end
         end
         D_ACK:   w_state_nxt = D_IDLE;
         default: w_state_nxt = D_IDLE;
      endcase
      // A reset cycle must never hand the port to debug nor stall the core.
      if (reset)
         w_grant = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= D_IDLE;
         r_ack   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_grant;
         if (w_grant)
            r_rdata <= mem_rdata;
      end
   end

   // A stalled core access is withheld; the core re-presents it next cycle.
   assign mem_we     = ~reset & (w_grant ? (dbg_req & dbg_we)
                                         : (core_req & core_we & ~core_stall));
   assign mem_addr   = w_grant ? dbg_addr  : core_addr;
   assign mem_wdata  = w_grant ? dbg_wdata : core_wdata;
   assign core_rdata = mem_rdata;
   assign dbg_ack    = r_ack;
   assign dbg_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the MIPS core's MEM stage and a debug/monitor requester, such as a display or loader port. It sits between `mips` and `dmem`, where the core would otherwise drive `memwrite`, `dataaddr` and `writedata` directly. The core has priority. The debug port receives a bounded-latency grant and stalls the core only when starvation protection fires. Read data for the core passes through combinationally to the existing writeback register; debug read data is registered.

## Interface
- `STARVE_MAX`, default 4: consecutive denied cycles before the debug port is forced in. Legal range is 1..15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `core_req` in 1: core MEM stage has a load or store this cycle.
- `core_we` in 1: core store.
- `core_addr` in 32: core address (ALU output, M stage).
- `core_wdata` in 32: core store data.
- `core_rdata` out 32: equal to `mem_rdata` (combinational).
- `core_stall` out 1: core must hold its M stage. Combinational.
- `dbg_req` in 1: debug request. Held with stable `dbg_we`/`dbg_addr`/`dbg_wdata` until `dbg_ack` or abort.
- `dbg_we` in 1: debug write.
- `dbg_addr` in 32: debug address.
- `dbg_wdata` in 32: debug write data.
- `dbg_ack` out 1: one-cycle completion pulse. Registered.
- `dbg_rdata` out 32: debug read data. Registered; valid while `dbg_ack`=1, held until the next grant.
- `mem_we` out 1: to dmem write enable.
- `mem_addr` out 32: to dmem address.
- `mem_wdata` out 32: to dmem write data.
- `mem_rdata` in 32: from dmem; combinational read.

## Operation
- FSM states are D_IDLE, D_WAIT and D_ACK. There is a 4-bit starvation counter, `cnt`.
- Grant rule: in a "dbg grant" cycle the mem port is driven by `dbg_*`. Otherwise it is driven by `core_*`.
  - `mem_we` = `req & we` of the owner.
  - `mem_addr` and `mem_wdata` follow the owner even when it is idle.
- D_IDLE:
  - `dbg_req` and not `core_req`: dbg grant this cycle, go to D_ACK.
  - `dbg_req` and `core_req`: core served, `cnt`←1, go to D_WAIT.
  - Otherwise stay in D_IDLE.
- D_WAIT:
  - `dbg_req`=0: abort, go to D_IDLE, `cnt`←0, no ack.
  - Else if not `core_req`: dbg grant, go to D_ACK, `cnt`←0.
  - Else if `cnt`==`STARVE_MAX`: dbg grant with `core_stall`=1, go to D_ACK, `cnt`←0.
  - Else core served, `cnt`←`cnt`+1.
- D_ACK:
  - `dbg_ack`=1. The core always owns the port and is never stalled.
  - Go to D_IDLE unconditionally.
  - A `dbg_req` still high in D_ACK is ignored. It is sampled as a new request in the following cycle.
- On a dbg grant, `dbg_rdata`←`mem_rdata` at the closing edge; this happens for writes as well. A store's effect on dmem is visible to any read issued on a later cycle.
- While `core_stall`=1, core requests never reach `mem_we`. The core re-presents the same access the next cycle.
- Reset, including mid-transaction, forces:
  - state D_IDLE, `cnt`=0, `dbg_ack`=0, `dbg_rdata`=0;
  - `mem_we`=0 and `core_stall`=0 during reset cycles.
  - An in-flight debug access is dropped without ack.

## Timing
- Debug latency: `dbg_ack` arrives 1 cycle after the grant cycle.
  - Best case (core idle): `dbg_req` at cycle n, grant at n, ack at n+1.
  - Worst case with the starvation bound: grant at n+`STARVE_MAX`, ack at n+`STARVE_MAX`+1.
- `core_stall` lasts at most 1 cycle per debug transaction. Stalls are separated by at least `STARVE_MAX`+1 cycles under continuous requests.
- Core read path is 0 added cycles. `core_rdata` = `mem_rdata` in the same cycle.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: behaviour as above.
- `DMEM_ARB_STARVE_EN` undefined:
  - no counter;
  - D_WAIT leaves only on `!core_req` or abort;
  - `core_stall` is tied 0;
  - debug latency is unbounded; `STARVE_MAX` is unused.

## Test plan
- Core idle, debug read of addr 0x40 holding 0x1234_5678 at cycle 10 → `mem_addr`=0x40 at 10; `dbg_ack`=1 and `dbg_rdata`=0x1234_5678 at 11; `core_stall` never 1.
- `core_req`=1 continuously, debug write 0xCAFE to 0x10, `STARVE_MAX`=4, req at cycle 0 → core served cycles 0–3; at cycle 4 `core_stall`=1, `mem_we`=1, `mem_addr`=0x10; `dbg_ack` at 5; core store presented at 4 lands at 5.
- Core store to 0x20 at cycle 3, debug read of 0x20 granted at cycle 4 → `dbg_rdata` returns the new value at ack cycle 5.
- Debug request in D_WAIT drops `dbg_req` at cycle 2 → state D_IDLE at 3; no `dbg_ack`; `mem_we` never driven by debug.
- `reset` asserted in D_ACK or D_WAIT → next cycle `dbg_ack`=0, `dbg_rdata`=0, `core_stall`=0, `mem_we`=0.
- Build without `DMEM_ARB_STARVE_EN`, `core_req` high for 20 cycles with debug pending → no grant and no stall for 20 cycles; grant in the first cycle `core_req`=0, ack the next cycle.
